clk_analyzer: RTL and testbench

- Measurement counterpart to the two-phase clock generator: observes the generated clk0/clk1 pair and reports back the duty cycle and phase it measures, in the same 3-bit word format the generator accepts.
- Used in self-test to close the loop on the generator's configuration: the generator is given duty first, then phase, and this block returns duty first, then phase.
- Same clock domain as the generator; no synchronisers on the inputs.

---
 rtl/clk_analyzer.sv | 249 ++++++++++++++++++++++++
 tb/tb_clk_analyzer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_analyzer.sv
// clk_analyzer: measures the duty cycle and phase of a two-phase clock pair
// (clk0_in / clk1_in) that runs in the clk domain, and reports them as DW-bit
// words in the same format the two-phase generator takes: duty first, then phase.
//
// Optional feature macro: CLK_ANALYZER_PERIOD_RPT_EN
//   When it is defined, a third word with the period (mod 2^DW) follows the phase word.
//
// Ports:
//   clk      in   system clock, posedge
//   rst      in   asynchronous, active-high reset
//   start    in   level request; low aborts and clears
//   clk0_in  in   observed primary clock (synchronous to clk)
//   clk1_in  in   observed phase-shifted clock (synchronous to clk)
//   dataout  out  result word, valid while valid=1
//   valid    out  one-cycle strobe per result word
//   done     out  measurement complete; held until start=0
//   err      out  measurement failed; held until start=0
module clk_analyzer #(
    parameter int unsigned DW      = 3,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          clk0_in,
    input  logic          clk1_in,
    output logic [DW-1:0] dataout,
    output logic          valid,
    output logic          done,
    output logic          err
);

    localparam int unsigned TW = $clog2(TIMEOUT) + 1;
    localparam int unsigned IW = 2;
`ifdef CLK_ANALYZER_PERIOD_RPT_EN
    localparam int unsigned NWORDS = 3;
`else
    localparam int unsigned NWORDS = 2;
`endif
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NWORDS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        MEAS   = 3'd2,
        REPORT = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic          s0_q, s0_d, s1_q, s1_d, p0_q, p0_d, p1_q, p1_d;
    logic [TW-1:0] t_q, t_d;
    logic [TW-1:0] duty_q, duty_d;
    logic [TW-1:0] phase_q, phase_d;
    logic          dfound_q, dfound_d;
    logic          pfound_q, pfound_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [DW-1:0] dataout_q, dataout_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
`ifdef CLK_ANALYZER_PERIOD_RPT_EN
    logic [TW-1:0] period_q, period_d;
`endif

    logic rise0, fall0, rise1;
    logic duty_fits, phase_fits;

    // Edge detection on the registered samples (one clk behind the inputs)
    assign rise0 = s0_q & ~p0_q;
    assign fall0 = ~s0_q & p0_q;
    assign rise1 = s1_q & ~p1_q;

    // Measured values must fit in one DW-bit word
    assign duty_fits  = (duty_q >> DW) == '0;
    assign phase_fits = (phase_q >> DW) == '0;

    // State, sample and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            s0_q      <= 1'b0;
            s1_q      <= 1'b0;
            p0_q      <= 1'b0;
            p1_q      <= 1'b0;
            t_q       <= '0;
            duty_q    <= '0;
            phase_q   <= '0;
            dfound_q  <= 1'b0;
            pfound_q  <= 1'b0;
            idx_q     <= '0;
            dataout_q <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef CLK_ANALYZER_PERIOD_RPT_EN
            period_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            p0_q      <= p0_d;
            p1_q      <= p1_d;
            t_q       <= t_d;
            duty_q    <= duty_d;
            phase_q   <= phase_d;
            dfound_q  <= dfound_d;
            pfound_q  <= pfound_d;
            idx_q     <= idx_d;
            dataout_q <= dataout_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef CLK_ANALYZER_PERIOD_RPT_EN
            period_q  <= period_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        s0_d      = clk0_in;
        s1_d      = clk1_in;
        p0_d      = s0_q;
        p1_d      = s1_q;
        t_d       = t_q;
        duty_d    = duty_q;
        phase_d   = phase_q;
        dfound_d  = dfound_q;
        pfound_d  = pfound_q;
        idx_d     = idx_q;
        dataout_d = dataout_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
`ifdef CLK_ANALYZER_PERIOD_RPT_EN
        period_d  = period_q;
`endif

        if (!start) begin
            state_d   = IDLE;
            t_d       = '0;
            dataout_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = ARM;
                    t_d       = '0;
                    dataout_d = '0;
                end

                ARM: begin
                    if (rise0) begin
                        // The rise cycle is t=0, so MEAS starts at t=1
                        duty_d   = '0;
                        phase_d  = '0;
                        dfound_d = 1'b0;
                        pfound_d = rise1;
                        t_d      = TW'(1);
                        state_d  = MEAS;
                    end else if (t_q >= T_LAST) begin
                        state_d   = ERR;
                        err_d     = 1'b1;
                        dataout_d = '0;
                    end else begin
                        t_d = t_q + TW'(1);
                    end
                end

                MEAS: begin
                    t_d = t_q + TW'(1);
                    if (rise0) begin
                        // Period closes; a rise1 on this cycle belongs to the next period
                        idx_d = '0;
`ifdef CLK_ANALYZER_PERIOD_RPT_EN
                        period_d = t_q;
`endif
                        if (dfound_q && pfound_q && duty_fits && phase_fits) begin
                            state_d = REPORT;
                        end else begin
                            state_d   = ERR;
                            err_d     = 1'b1;
                            dataout_d = '0;
                        end
                    end else begin
                        if (fall0 && !dfound_q) begin
                            duty_d   = t_q;
                            dfound_d = 1'b1;
                        end
                        if (rise1 && !pfound_q) begin
                            phase_d  = t_q;
                            pfound_d = 1'b1;
                        end
                        if (t_q >= T_LAST) begin
                            state_d   = ERR;
                            err_d     = 1'b1;
                            dataout_d = '0;
                        end
                    end
                end

                REPORT: begin
                    valid_d = 1'b1;
                    if (idx_q == '0) begin
                        dataout_d = duty_q[DW-1:0];
`ifdef CLK_ANALYZER_PERIOD_RPT_EN
                    end else if (idx_q == IW'(1)) begin
                        dataout_d = phase_q[DW-1:0];
                    end else begin
                        dataout_d = period_q[DW-1:0];
                    end
`else
                    end else begin
                        dataout_d = phase_q[DW-1:0];
                    end
`endif
                    idx_d = idx_q + IW'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                    end
                end

                DONE: begin
                    done_d = 1'b1;
                end

                ERR: begin
                    err_d     = 1'b1;
                    dataout_d = '0;
                end

                default: begin
                    state_d   = IDLE;
                    dataout_d = '0;
                end
            endcase
        end
    end

    assign dataout = dataout_q;
    assign valid   = valid_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_clk_analyzer.sv
// Bench for clk_analyzer: a two-phase clock pattern generator drives the
// observed inputs; expected words are queued per measurement and compared
// against each valid strobe.
module tb_clk_analyzer;

    localparam int unsigned DW      = 3;
    localparam int unsigned TIMEOUT = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          clk0_in;
    logic          clk1_in;
    logic [DW-1:0] dataout;
    logic          valid;
    logic          done;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] exp_q[$];

    // Pattern generator settings
    int gen_per = 8;
    int gen_hi0 = 3;
    int gen_ph  = 2;
    int gen_hi1 = 3;
    bit gen_en  = 1'b0;
    int gen_cnt = 0;

    clk_analyzer #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .clk0_in (clk0_in),
        .clk1_in (clk1_in),
        .dataout (dataout),
        .valid   (valid),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Two-phase clock source, updated away from the sampling edge
    always @(negedge clk) begin
        if (!gen_en) begin
            gen_cnt = 0;
            clk0_in = 1'b0;
            clk1_in = 1'b0;
        end else begin
            clk0_in = (gen_cnt < gen_hi0);
            clk1_in = (((gen_cnt + gen_per - gen_ph) % gen_per) < gen_hi1);
            gen_cnt = (gen_cnt + 1) % gen_per;
        end
    end

    // Scoreboard: every valid strobe consumes one expected word
    always @(negedge clk) begin
        if (rst === 1'b0 && valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_valid", int'(valid), 0);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                check_eq("word", int'(dataout), int'(e));
            end
        end
    end

    task automatic cfg(input int per, input int hi0, input int ph, input int hi1);
        gen_per = per;
        gen_hi0 = hi0;
        gen_ph  = ph;
        gen_hi1 = hi1;
    endtask

    task automatic push_words(input int duty, input int phase, input int per);
        exp_q.push_back(DW'(duty));
        exp_q.push_back(DW'(phase));
`ifdef CLK_ANALYZER_PERIOD_RPT_EN
        exp_q.push_back(DW'(per % (1 << DW)));
`else
        if (per < 0) exp_q.push_back('0);
`endif
    endtask

    task automatic wait_end(input int limit, output int cycles);
        cycles = 0;
        while (!(done === 1'b1 || err === 1'b1) && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic finish_meas(input string tag);
        start  = 1'b0;
        gen_en = 1'b0;
        @(negedge clk);
        check_eq({tag, "_err_clr"}, int'(err), 0);
        check_eq({tag, "_done_clr"}, int'(done), 0);
        check_eq({tag, "_valid_clr"}, int'(valid), 0);
        @(negedge clk);
    endtask

    task automatic good_meas(input string tag, input int per, input int hi0,
                             input int ph, input int hi1, input int wd, input int wp);
        int cyc;
        cfg(per, hi0, ph, hi1);
        push_words(wd, wp, per);
        start = 1'b1;
        @(negedge clk);
        gen_en = 1'b1;
        wait_end(80, cyc);
        check_eq({tag, "_done"}, int'(done), 1);
        check_eq({tag, "_err"}, int'(err), 0);
        check_eq({tag, "_left"}, exp_q.size(), 0);
        exp_q.delete();
        finish_meas(tag);
    endtask

    task automatic bad_meas(input string tag, input int per, input int hi0,
                            input int ph, input int hi1, output int cyc);
        cfg(per, hi0, ph, hi1);
        start = 1'b1;
        @(negedge clk);
        gen_en = 1'b1;
        wait_end(100, cyc);
        check_eq({tag, "_err"}, int'(err), 1);
        check_eq({tag, "_done"}, int'(done), 0);
        check_eq({tag, "_dataout"}, int'(dataout), 0);
        finish_meas(tag);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        int lat_ok;
        rst     = 1'b1;
        start   = 1'b0;
        clk0_in = 1'b0;
        clk1_in = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_dataout", int'(dataout), 0);
        check_eq("rst_valid", int'(valid), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_err", int'(err), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Nominal: period 8, duty 3, phase 2
        good_meas("nominal", 8, 3, 2, 3, 3, 2);
        // Coincident edges: phase 0
        good_meas("phase0", 8, 5, 0, 3, 5, 0);
        // Short period, single-cycle clk1 pulse
        good_meas("per6", 6, 2, 4, 1, 2, 4);

        // clk0 stuck high: timeout in the measurement phase
        bad_meas("stuck_hi", 8, 8, 2, 3, cyc);
        lat_ok = (cyc >= TIMEOUT - 2 && cyc <= TIMEOUT + 4) ? 1 : 0;
        check_eq("stuck_hi_latency", lat_ok, 1);

        // clk1 never rises: error at the closing clk0 rise
        bad_meas("no_clk1", 8, 4, 2, 0, cyc);
        lat_ok = (cyc >= 8 && cyc <= 12) ? 1 : 0;
        check_eq("no_clk1_latency", lat_ok, 1);

        // Duty does not fit in a DW-bit word
        bad_meas("duty_wide", 12, 9, 2, 3, cyc);

        // Abort between the first and second word
        cfg(8, 3, 2, 3);
        push_words(3, 2, 8);
        start = 1'b1;
        @(negedge clk);
        gen_en = 1'b1;
        cyc = 0;
        while (valid !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("abort_first_valid", int'(valid), 1);
        start = 1'b0;
        @(negedge clk);
        check_eq("abort_valid", int'(valid), 0);
        check_eq("abort_dataout", int'(dataout), 0);
        check_eq("abort_done", int'(done), 0);
        check_eq("abort_left", exp_q.size(), 1 + ((exp_q.size() > 1) ? 1 : 0));
        @(negedge clk);
        check_eq("abort_no_word2", int'(valid), 0);
        exp_q.delete();
        gen_en = 1'b0;
        @(negedge clk);
        good_meas("remeasure", 8, 3, 2, 3, 3, 2);

        // Asynchronous reset in the middle of a measurement
        cfg(8, 3, 2, 3);
        start = 1'b1;
        @(negedge clk);
        gen_en = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midrst_valid", int'(valid), 0);
        check_eq("midrst_done", int'(done), 0);
        check_eq("midrst_err", int'(err), 0);
        check_eq("midrst_dataout", int'(dataout), 0);
        @(negedge clk);
        rst = 1'b0;
        push_words(3, 2, 8);
        wait_end(80, cyc);
        check_eq("postrst_done", int'(done), 1);
        check_eq("postrst_err", int'(err), 0);
        check_eq("postrst_left", exp_q.size(), 0);
        exp_q.delete();
        finish_meas("postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
